// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel gradient units: two line buffers plus a 3x3 shift window.
// Optional output register stage on the window/handshake outputs: define SOBEL_WIN_OUT_REG_EN.
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic       pix_ready,
    input  logic       win_ready,
    output logic [7:0] P0,
    output logic [7:0] P1,
    output logic [7:0] P2,
    output logic [7:0] P3,
    output logic [7:0] P4,
    output logic [7:0] P5,
    output logic [7:0] P6,
    output logic [7:0] P7,
    output logic [7:0] P8,
    output logic       win_valid,
    output logic       start_calculations,
    output logic       frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_eff;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_eff;
    logic             accept;
    logic             emit;
    logic             is_last;
    logic             core_valid;
    logic             core_ready;
    logic [7:0]       win_q [9];
    logic [7:0]       p_out [9];
    logic [7:0]       lb0   [IMG_WIDTH];
    logic [7:0]       lb1   [IMG_WIDTH];

    // A sof pixel is always taken as (0,0), discarding any partial frame.
    always_comb begin
        col_eff   = sof ? '0 : col_q;
        row_eff   = sof ? '0 : row_q;
        pix_ready = !core_valid || core_ready;
        accept    = pix_valid && pix_ready;
        emit      = accept && (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
        is_last   = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    end

    // Raster position counters and the 3x3 shift window.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q <= '0;
            row_q <= '0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (accept) begin
            if (col_eff == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
            end else begin
                col_q <= col_eff + COL_W'(1);
                row_q <= row_eff;
            end
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= lb0[col_eff];
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[5] <= lb1[col_eff];
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
            win_q[8] <= pix_in;
        end
    end

    // Line buffers hold rows r-2 (lb0) and r-1 (lb1); contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_eff] <= lb1[col_eff];
            lb1[col_eff] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            core_valid <= 1'b0;
        end else if (emit) begin
            core_valid <= 1'b1;
        end else if (core_ready) begin
            core_valid <= 1'b0;
        end
    end

`ifdef SOBEL_WIN_OUT_REG_EN
    logic       core_last;
    logic       out_valid;
    logic       out_fd;
    logic [7:0] out_win [9];

    assign core_ready = !out_valid || win_ready;

    // Tags the held core window as the last of its frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            core_last <= 1'b0;
        end else if (emit) begin
            core_last <= is_last;
        end
    end

    // Output skid stage; frame_done pulses only on the cycle the last window lands.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            out_fd    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                out_win[i] <= '0;
            end
        end else if (core_valid && core_ready) begin
            out_valid <= 1'b1;
            out_fd    <= core_last;
            out_win   <= win_q;
        end else begin
            out_fd <= 1'b0;
            if (win_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign p_out      = out_win;
    assign win_valid  = out_valid;
    assign frame_done = out_fd;
`else
    logic fd_q;

    assign core_ready = win_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fd_q <= 1'b0;
        end else begin
            fd_q <= emit && is_last;
        end
    end

    assign p_out      = win_q;
    assign win_valid  = core_valid;
    assign frame_done = fd_q;
`endif

    assign start_calculations = win_valid;
    assign P0 = p_out[0];
    assign P1 = p_out[1];
    assign P2 = p_out[2];
    assign P3 = p_out[3];
    assign P4 = p_out[4];
    assign P5 = p_out[5];
    assign P6 = p_out[6];
    assign P7 = p_out[7];
    assign P8 = p_out[8];

endmodule
